pcie_us_cq_axil_wr: RTL and testbench



---
 rtl/pcie_us_cq_axil_wr_if.sv | 41 ++++
 rtl/pcie_us_cq_axil_wr.sv | 190 +++++++++++++++++++
 tb/tb_pcie_us_cq_axil_wr.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_us_cq_axil_wr_if.sv
// Bus bundle for the CQ-to-AXI-Lite write bridge: 128-bit CQ stream plus AXI-Lite write channels.
// slave = the bridge (CQ sink, AXI-Lite issuer); master = PCIe core and register fabric side.
interface pcie_us_cq_axil_wr_if #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH/32,
  parameter int USER_WIDTH = 85,
  parameter int ADDR_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready,
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready,
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/pcie_us_cq_axil_wr.sv
// Terminates posted memory-write TLPs from the 128-bit UltraScale CQ stream and replays
// each payload DWORD as a single AXI-Lite write; any other request is drained and flagged.
module pcie_us_cq_axil_wr #(
  parameter int AXIS_PCIE_DATA_WIDTH    = 128,
  parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH/32,
  parameter int AXIS_PCIE_CQ_USER_WIDTH = 85,
  parameter int AXIL_ADDR_WIDTH         = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pcie_us_cq_axil_wr_if.slave       bus,
  output logic                      status_error_uncor,
  output logic                      busy
);
  localparam int DW_ADDR_WIDTH = AXIL_ADDR_WIDTH - 2;

  typedef enum logic [2:0] {IDLE, DATA, WRITE, RESP, DROP} state_t;

  state_t                     state_reg, state_next;
  logic [DW_ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [10:0]                dword_count_reg, dword_count_next;
  logic [10:0]                idx_reg, idx_next;
  logic [3:0]                 first_be_reg, first_be_next;
  logic [3:0]                 last_be_reg, last_be_next;
  logic [127:0]               lane_data_reg;
  logic [3:0]                 keep_reg, keep_next;
  logic                       last_seen_reg, last_seen_next;
  logic [1:0]                 lane_idx_reg, lane_idx_next;
  logic                       aw_done_reg, aw_done_next;
  logic                       w_done_reg, w_done_next;
  logic                       error_reg, error_next;
  logic                       tready_reg;
  logic                       beat_load;
  logic                       aw_ok, w_ok;

  logic       cq_fire;
  logic [3:0] req_type;
  logic [10:0] desc_dword_count;
  logic       unused_user;

  assign cq_fire          = bus.tvalid && tready_reg;
  assign req_type         = bus.tdata[78:75];
  assign desc_dword_count = bus.tdata[74:64];
  assign unused_user      = ^{bus.tuser[AXIS_PCIE_CQ_USER_WIDTH-1:12], bus.tuser[7:4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      dword_count_reg <= '0;
      idx_reg         <= '0;
      first_be_reg    <= '0;
      last_be_reg     <= '0;
      lane_data_reg   <= '0;
      keep_reg        <= '0;
      last_seen_reg   <= 1'b0;
      lane_idx_reg    <= '0;
      aw_done_reg     <= 1'b0;
      w_done_reg      <= 1'b0;
      error_reg       <= 1'b0;
      tready_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      dword_count_reg <= dword_count_next;
      idx_reg         <= idx_next;
      first_be_reg    <= first_be_next;
      last_be_reg     <= last_be_next;
      keep_reg        <= keep_next;
      last_seen_reg   <= last_seen_next;
      lane_idx_reg    <= lane_idx_next;
      aw_done_reg     <= aw_done_next;
      w_done_reg      <= w_done_next;
      error_reg       <= error_next;
      // Registered ready: only stalled while an AXI-Lite transaction is in flight.
      tready_reg      <= (state_next == IDLE) || (state_next == DATA) || (state_next == DROP);
      if (beat_load) begin
        lane_data_reg <= bus.tdata;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    dword_count_next = dword_count_reg;
    idx_next         = idx_reg;
    first_be_next    = first_be_reg;
    last_be_next     = last_be_reg;
    keep_next        = keep_reg;
    last_seen_next   = last_seen_reg;
    lane_idx_next    = lane_idx_reg;
    aw_done_next     = aw_done_reg;
    w_done_next      = w_done_reg;
    error_next       = 1'b0;
    beat_load        = 1'b0;
    aw_ok            = 1'b0;
    w_ok             = 1'b0;
    bus.awvalid      = 1'b0;
    bus.wvalid       = 1'b0;
    bus.bready       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cq_fire) begin
          addr_next        = bus.tdata[AXIL_ADDR_WIDTH-1:2];
          dword_count_next = desc_dword_count;
          first_be_next    = bus.tuser[3:0];
          last_be_next     = bus.tuser[11:8];
          idx_next         = '0;
          last_seen_next   = 1'b0;
          if (req_type == 4'b0001 && !bus.tlast && desc_dword_count != 11'd0) begin
            state_next = DATA;
          end else begin
            // Non-write, empty write or zero-length write: flag it and drain the rest.
            error_next = 1'b1;
            state_next = bus.tlast ? IDLE : DROP;
          end
        end
      end
      DATA: begin
        if (cq_fire) begin
          beat_load      = 1'b1;
          keep_next      = bus.tkeep;
          last_seen_next = bus.tlast;
          lane_idx_next  = '0;
          aw_done_next   = 1'b0;
          w_done_next    = 1'b0;
          if (bus.tlast && !bus.tkeep[0]) begin
            error_next = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        bus.awvalid = !aw_done_reg;
        bus.wvalid  = !w_done_reg;
        aw_ok       = aw_done_reg || bus.awready;
        w_ok        = w_done_reg || bus.wready;
        if (aw_ok && w_ok) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = RESP;
        end else begin
          aw_done_next = aw_ok;
          w_done_next  = w_ok;
        end
      end
      RESP: begin
        bus.bready = 1'b1;
        if (bus.bvalid) begin
          error_next = (bus.bresp != 2'b00);
          idx_next   = idx_reg + 11'd1;
          if (idx_reg + 11'd1 == dword_count_reg) begin
            state_next = last_seen_reg ? IDLE : DROP;
          end else if (last_seen_reg && (lane_idx_reg == 2'd3 || !keep_reg[lane_idx_reg + 2'd1])) begin
            // Packet ended before dword_count was satisfied.
            error_next = 1'b1;
            state_next = IDLE;
          end else if (lane_idx_reg == 2'd3) begin
            state_next = DATA;
          end else begin
            lane_idx_next = lane_idx_reg + 2'd1;
            state_next    = WRITE;
          end
        end
      end
      DROP: begin
        if (cq_fire && bus.tlast) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.tready  = tready_reg;
  assign bus.awaddr  = {addr_reg + DW_ADDR_WIDTH'(idx_reg), 2'b00};
  assign bus.awprot  = 3'b010;
  assign bus.wdata   = lane_data_reg[32*lane_idx_reg +: 32];
  assign bus.wstrb   = (dword_count_reg == 11'd1 || idx_reg == 11'd0) ? first_be_reg :
                       (idx_reg == dword_count_reg - 11'd1)           ? last_be_reg  : 4'hF;

  assign status_error_uncor = error_reg;
  assign busy               = (state_reg != IDLE);
endmodule

// File: tb/tb_pcie_us_cq_axil_wr.sv
// Scoreboard bench for the CQ memory-write to AXI-Lite bridge with a reactive AXI-Lite slave model.
module tb_pcie_us_cq_axil_wr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic status_error_uncor;
  logic busy;

  always #5 clk = ~clk;

  pcie_us_cq_axil_wr_if #(.DATA_WIDTH(128), .KEEP_WIDTH(4), .USER_WIDTH(85), .ADDR_WIDTH(32)) bus ();

  pcie_us_cq_axil_wr #(
    .AXIS_PCIE_DATA_WIDTH(128), .AXIS_PCIE_KEEP_WIDTH(4),
    .AXIS_PCIE_CQ_USER_WIDTH(85), .AXIL_ADDR_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .status_error_uncor(status_error_uncor), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  int vectors = 0;
  int miscompares = 0;
  wr_t exp_q[$];
  logic [31:0] obs_aw_q[$];
  logic [35:0] obs_w_q[$];

  int aw_n = 0, w_n = 0, b_n = 0;
  int err_idx = -1, aw_delay = 0, w_delay = 0;
  int aw_wait = 0, w_wait = 0;
  int err_cnt = 0, order_viol = 0;
  bit b_taken = 1'b0;

  // AXI-Lite slave: decisions are made on the falling edge, handshakes complete on the next rising edge.
  initial begin
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (status_error_uncor) err_cnt++;
      if (!rst_n) begin
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
        b_taken = 1'b0; aw_n = 0; w_n = 0; b_n = 0; aw_wait = 0; w_wait = 0;
      end else begin
        if (b_taken) begin bus.bvalid = 1'b0; b_taken = 1'b0; b_n++; end
        if (bus.awvalid && aw_n > b_n) order_viol++;
        if (bus.wvalid && w_n > b_n) order_viol++;
        if (!bus.bvalid && aw_n > b_n && w_n > b_n) begin
          bus.bvalid = 1'b1;
          bus.bresp  = (b_n == err_idx) ? 2'b10 : 2'b00;
        end
        if (bus.bvalid && bus.bready) b_taken = 1'b1;
        if (bus.awvalid && aw_wait >= aw_delay) begin
          bus.awready = 1'b1; obs_aw_q.push_back(bus.awaddr); aw_n++; aw_wait = 0;
        end else begin
          bus.awready = 1'b0; if (bus.awvalid) aw_wait++;
        end
        if (bus.wvalid && w_wait >= w_delay) begin
          bus.wready = 1'b1; obs_w_q.push_back({bus.wstrb, bus.wdata}); w_n++; w_wait = 0;
        end else begin
          bus.wready = 1'b0; if (bus.wvalid) w_wait++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] desc(input logic [31:0] a, input logic [10:0] dwc, input logic [3:0] rt);
    logic [127:0] d;
    d = '0;
    d[31:0]  = a;
    d[63:32] = 32'h0000_0005;
    d[74:64] = dwc;
    d[78:75] = rt;
    return d;
  endfunction

  function automatic wr_t pop_obs();
    wr_t g;
    logic [35:0] w;
    g = 'x;
    if (obs_aw_q.size() != 0 && obs_w_q.size() != 0) begin
      g.addr = obs_aw_q.pop_front();
      w      = obs_w_q.pop_front();
      g.data = w[31:0];
      g.strb = w[35:32];
    end
    return g;
  endfunction

  // Called on a falling edge; returns on the falling edge after the beat was accepted.
  task automatic send_beat(input logic [127:0] d, input logic [3:0] k, input logic l,
                           input logic [3:0] fbe, input logic [3:0] lbe);
    int t = 0;
    bus.tdata = d; bus.tkeep = k; bus.tlast = l;
    bus.tuser = '0; bus.tuser[3:0] = fbe; bus.tuser[11:8] = lbe;
    bus.tvalid = 1'b1;
    while (!bus.tready && t < 300) begin @(negedge clk); t++; end
    if (!bus.tready) begin
      vectors++; miscompares++;
      $display("FAIL cq_accept: tready=%b, required 1 within 300 cycles", bus.tready);
    end
    @(negedge clk);
    bus.tvalid = 1'b0; bus.tlast = 1'b0;
  endtask

  // Memory-write TLP declaring dwc DWORDs but carrying nsend payload DWORDs.
  task automatic send_mwr(input logic [31:0] a, input int dwc, input int nsend,
                          input logic [3:0] fbe, input logic [3:0] lbe, input logic [31:0] seed);
    int nbeats;
    logic [127:0] d;
    logic [3:0] k;
    wr_t e;
    for (int i = 0; i < nsend && i < dwc; i++) begin
      e.addr = a + 32'(i * 4);
      e.data = seed + 32'(i) * 32'h0101_0101;
      e.strb = (dwc == 1 || i == 0) ? fbe : (i == dwc - 1) ? lbe : 4'hF;
      exp_q.push_back(e);
    end
    send_beat(desc(a, 11'(dwc), 4'b0001), 4'hF, nsend == 0, fbe, lbe);
    nbeats = (nsend + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      d = '0; k = '0;
      for (int l = 0; l < 4; l++) begin
        if (b * 4 + l < nsend) begin
          d[32*l +: 32] = seed + 32'(b * 4 + l) * 32'h0101_0101;
          k[l] = 1'b1;
        end
      end
      send_beat(d, k, b == nbeats - 1, fbe, lbe);
    end
  endtask

  task automatic wait_idle(output bit tmo);
    int t = 0;
    while (busy && t < 2000) begin @(negedge clk); t++; end
    tmo = busy;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.tvalid = 1'b0; bus.tlast = 1'b0; bus.tkeep = '0; bus.tdata = '0; bus.tuser = '0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready: got %b required 0", bus.tready); end
    vectors++; if (bus.awvalid !== 1'b0) begin miscompares++; $display("FAIL reset_awvalid: got %b required 0", bus.awvalid); end
    vectors++; if (bus.wvalid !== 1'b0) begin miscompares++; $display("FAIL reset_wvalid: got %b required 0", bus.wvalid); end
    vectors++; if (bus.bready !== 1'b0) begin miscompares++; $display("FAIL reset_bready: got %b required 0", bus.bready); end
    vectors++; if (status_error_uncor !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b required 0", status_error_uncor); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (bus.tready !== 1'b1) begin miscompares++; $display("FAIL idle_tready: got %b required 1", bus.tready); end
    vectors++; if (bus.awprot !== 3'b010) begin miscompares++; $display("FAIL awprot: got %b required 010", bus.awprot); end
    $display("test_reset done");
  endtask

  task automatic test_single_dw();
    int e0 = err_cnt;
    bit tmo;
    wr_t e, g;
    send_mwr(32'h0000_1004, 1, 1, 4'hF, 4'hF, 32'hDEAD_BEEF);
    wait_idle(tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL single_dw_idle: busy=1 required 0"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = pop_obs(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL single_dw_write: got %h required %h (addr,data,strb)", g, e); end
      else $display("single_dw write addr=%h data=%h strb=%h", g.addr, g.data, g.strb);
    end
    vectors++; if (obs_aw_q.size() != 0) begin miscompares++; $display("FAIL single_dw_extra: %0d extra writes, required 0", obs_aw_q.size()); end
    vectors++; if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL single_dw_err: %0d pulses required 0", err_cnt - e0); end
  endtask

  task automatic test_multi_dw();
    int e0 = err_cnt;
    bit tmo;
    wr_t e, g;
    send_mwr(32'h0000_2000, 6, 6, 4'hE, 4'h3, 32'hA000_0000);
    wait_idle(tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL multi_dw_idle: busy=1 required 0"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = pop_obs(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL multi_dw_write: got %h required %h (addr,data,strb)", g, e); end
      else $display("multi_dw write addr=%h data=%h strb=%h", g.addr, g.data, g.strb);
    end
    vectors++; if (obs_aw_q.size() != 0) begin miscompares++; $display("FAIL multi_dw_extra: %0d extra writes, required 0", obs_aw_q.size()); end
    vectors++; if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL multi_dw_err: %0d pulses required 0", err_cnt - e0); end
  endtask

  task automatic test_unsupported();
    int e0 = err_cnt;
    int a0 = aw_n;
    bit tmo;
    send_beat(desc(32'h0000_3000, 11'd1, 4'b0000), 4'hF, 1'b1, 4'hF, 4'h0);
    vectors++; if (bus.tready !== 1'b1) begin miscompares++; $display("FAIL rd_tready: got %b required 1", bus.tready); end
    repeat (3) @(negedge clk);
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL rd_err: %0d pulses required 1", err_cnt - e0); end
    vectors++; if (aw_n != a0 || bus.awvalid !== 1'b0) begin miscompares++; $display("FAIL rd_axil: %0d writes required 0", aw_n - a0); end
    $display("unsupported read: err pulses=%0d writes=%0d", err_cnt - e0, aw_n - a0);
    e0 = err_cnt;
    send_beat(desc(32'h0000_3000, 11'd4, 4'b0010), 4'hF, 1'b0, 4'hF, 4'hF);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL drop_busy: got %b required 1", busy); end
    send_beat(128'h1234, 4'hF, 1'b1, 4'hF, 4'hF);
    wait_idle(tmo);
    vectors++; if (tmo || err_cnt - e0 != 1 || aw_n != a0) begin
      miscompares++; $display("FAIL drop_tlp: busy=%b pulses=%0d writes=%0d required 0,1,0", tmo, err_cnt - e0, aw_n - a0);
    end
    $display("unsupported with payload: err pulses=%0d writes=%0d", err_cnt - e0, aw_n - a0);
  endtask

  task automatic test_bresp_err();
    int e0 = err_cnt;
    bit tmo;
    wr_t e, g;
    err_idx = b_n + 1;
    send_mwr(32'h0000_0100, 3, 3, 4'hF, 4'hF, 32'h5500_0000);
    wait_idle(tmo);
    err_idx = -1;
    vectors++; if (tmo) begin miscompares++; $display("FAIL bresp_idle: busy=1 required 0"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = pop_obs(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL bresp_write: got %h required %h (addr,data,strb)", g, e); end
      else $display("bresp write addr=%h data=%h strb=%h", g.addr, g.data, g.strb);
    end
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL bresp_err: %0d pulses required 1", err_cnt - e0); end
  endtask

  task automatic test_aw_delay();
    int v0 = order_viol;
    bit tmo;
    wr_t e, g;
    aw_delay = 5;
    send_mwr(32'h0000_4000, 3, 3, 4'h7, 4'hC, 32'h0BAD_F00D);
    wait_idle(tmo);
    aw_delay = 0;
    vectors++; if (tmo) begin miscompares++; $display("FAIL aw_delay_idle: busy=1 required 0"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = pop_obs(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL aw_delay_write: got %h required %h (addr,data,strb)", g, e); end
      else $display("aw_delay write addr=%h data=%h strb=%h", g.addr, g.data, g.strb);
    end
    vectors++; if (order_viol != v0) begin miscompares++; $display("FAIL aw_delay_outstanding: %0d valids after handshake, required 0", order_viol - v0); end
  endtask

  task automatic test_early_tlast();
    int e0 = err_cnt;
    bit tmo;
    wr_t e, g;
    send_mwr(32'h0000_6000, 6, 3, 4'h1, 4'h8, 32'h7700_0000);
    wait_idle(tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL early_tlast_idle: busy=1 required 0"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = pop_obs(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL early_tlast_write: got %h required %h (addr,data,strb)", g, e); end
      else $display("early_tlast write addr=%h data=%h strb=%h", g.addr, g.data, g.strb);
    end
    vectors++; if (obs_aw_q.size() != 0) begin miscompares++; $display("FAIL early_tlast_extra: %0d extra writes, required 0", obs_aw_q.size()); end
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL early_tlast_err: %0d pulses required 1", err_cnt - e0); end
  endtask

  task automatic test_excess_and_wrap();
    int e0 = err_cnt;
    bit tmo;
    wr_t e, g;
    send_mwr(32'h0000_7000, 2, 6, 4'hC, 4'h3, 32'h1100_0000);
    send_mwr(32'hFFFF_FFF8, 3, 3, 4'hF, 4'hF, 32'h2200_0000);
    wait_idle(tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL excess_wrap_idle: busy=1 required 0"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = pop_obs(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL excess_wrap_write: got %h required %h (addr,data,strb)", g, e); end
      else $display("excess_wrap write addr=%h data=%h strb=%h", g.addr, g.data, g.strb);
    end
    vectors++; if (obs_aw_q.size() != 0) begin miscompares++; $display("FAIL excess_wrap_extra: %0d extra writes, required 0", obs_aw_q.size()); end
    vectors++; if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL excess_wrap_err: %0d pulses required 0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    wr_t e, g;
    send_mwr(32'h0000_8000, 1, 1, 4'h3, 4'h3, 32'h0000_0011);
    send_mwr(32'h0000_8010, 2, 2, 4'hF, 4'h1, 32'h0000_0022);
    send_mwr(32'h0000_8020, 5, 5, 4'h8, 4'hF, 32'h0000_0033);
    wait_idle(tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL b2b_idle: busy=1 required 0"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = pop_obs(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL b2b_write: got %h required %h (addr,data,strb)", g, e); end
      else $display("b2b write addr=%h data=%h strb=%h", g.addr, g.data, g.strb);
    end
    vectors++; if (obs_aw_q.size() != 0) begin miscompares++; $display("FAIL b2b_extra: %0d extra writes, required 0", obs_aw_q.size()); end
  endtask

  task automatic test_reset_mid();
    int a0 = aw_n;
    int t = 0;
    bit tmo;
    wr_t e, g;
    aw_delay = 3;
    send_mwr(32'h0000_5000, 4, 4, 4'hF, 4'hF, 32'h3300_0000);
    while (!(aw_n - a0 == 1 && bus.awvalid) && t < 300) begin @(negedge clk); t++; end
    vectors++; if (t >= 300) begin miscompares++; $display("FAIL reset_mid_reach: second write not reached within 300 cycles"); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({bus.awvalid, bus.wvalid, bus.bready, busy, bus.tready} !== 5'b0) begin
      miscompares++; $display("FAIL reset_mid_outputs: awv,wv,br,busy,trdy=%b required 00000",
                              {bus.awvalid, bus.wvalid, bus.bready, busy, bus.tready});
    end
    repeat (3) @(negedge clk);
    exp_q.delete(); obs_aw_q.delete(); obs_w_q.delete();
    aw_delay = 0;
    rst_n = 1'b1;
    send_mwr(32'h0000_3000, 1, 1, 4'hF, 4'hF, 32'h1234_5678);
    wait_idle(tmo);
    vectors++; if (tmo) begin miscompares++; $display("FAIL reset_mid_idle: busy=1 required 0"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = pop_obs(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL reset_mid_write: got %h required %h (addr,data,strb)", g, e); end
      else $display("post-reset write addr=%h data=%h strb=%h", g.addr, g.data, g.strb);
    end
    vectors++; if (obs_aw_q.size() != 0) begin miscompares++; $display("FAIL reset_mid_extra: %0d extra writes, required 0", obs_aw_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_dw();
    test_multi_dw();
    test_unsupported();
    test_bresp_err();
    test_aw_delay();
    test_early_tlast();
    test_excess_and_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
